// File: rtl/shift_rows_pipe.sv
`default_nettype none
// =============================================================================
// Module      : shift_rows_pipe
// Description : AES/Rijndael ShiftRows (forward / inverse / bypass) applied at
//               acceptance, results buffered in a 2-entry in-order FIFO.
// Revision    : 1.0 - initial release
// =============================================================================
module shift_rows_pipe #(
   parameter int NB    = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_mode,
   input  logic [32*NB-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [32*NB-1:0]   out_data,
   output logic               out_mode_err,
   output logic [CNT_W-1:0]   xfer_cnt
);

   localparam int         W          = 32 * NB;
   localparam logic [1:0] C_MODE_FWD = 2'b00;
   localparam logic [1:0] C_MODE_INV = 2'b01;
   localparam logic [1:0] C_MODE_RSV = 2'b11;
   localparam logic [1:0] C_FULL     = 2'd2;

   // Rijndael row offsets: 256-bit blocks skip offset 2 on the lower rows.
   function automatic int row_shift(input int r);
      if (NB == 8)
         return (r < 2) ? r : r + 1;
      else
         return r;
   endfunction

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $fatal(1, "shift_rows_pipe: NB=%0d is not one of 4, 6, 8", NB);
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Byte permutation network (pure wiring)
   // ---------------------------------------------------------------------
   logic [W-1:0] w_fwd;
   logic [W-1:0] w_inv;
   logic [W-1:0] w_xform;
   logic         w_err;

   generate
      for (genvar c = 0; c < NB; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S  = row_shift(r);
            localparam int K  = 4 * c + r;
            localparam int KF = 4 * ((c + S) % NB) + r;
            localparam int KI = 4 * ((c + NB - S) % NB) + r;
            assign w_fwd[W-1-8*K -: 8] = in_data[W-1-8*KF -: 8];
            assign w_inv[W-1-8*K -: 8] = in_data[W-1-8*KI -: 8];
         end
      end
   endgenerate

   always_comb begin
      w_xform = in_data;
      case (in_mode)
         C_MODE_FWD: w_xform = w_fwd;
         C_MODE_INV: w_xform = w_inv;
         default:    w_xform = in_data;
      endcase
   end

   assign w_err = (in_mode == C_MODE_RSV);

   // ---------------------------------------------------------------------
   // Two-entry FIFO
   // ---------------------------------------------------------------------
   logic [W-1:0]     r_data [2];
   logic [1:0]       r_err;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             r_live;
   logic [CNT_W-1:0] r_xfer_cnt;
   logic             w_push;
   logic             w_pop;

   // r_live holds in_ready low until the first edge after reset release.
   assign in_ready     = r_live && (r_count != C_FULL);
   assign out_valid    = (r_count != 2'd0);
   assign out_data     = r_data[r_rd_ptr];
   assign out_mode_err = out_valid && r_err[r_rd_ptr];
   assign xfer_cnt     = r_xfer_cnt;

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
         end
         r_err      <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_live     <= 1'b0;
         r_xfer_cnt <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_push) begin
            r_data[r_wr_ptr] <= w_xform;
            r_err[r_wr_ptr]  <= w_err;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr   <= ~r_rd_ptr;
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4: state columns; legal values 4, 6, 8; state width W = 32*NB bits.
REQ-002 Parameter CNT_W, default 16: width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream has a state word available.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_mode  input  2  per-word mode: 00 forward ShiftRows, 01 inverse ShiftRows, 10 bypass, 11 reserved.
REQ-008 in_data  input  W  input state.
REQ-009 out_valid  output  1  out_data holds a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_data  output  W  transformed state.
REQ-012 out_mode_err  output  1  result at the head came from mode 11; qualified by out_valid.
REQ-013 xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-014 The state SHALL be byte-mapped column-major: byte k occupies bits [W-1-8k : W-8-8k]; row r = k mod 4, column c = k div 4.
REQ-015 Row shift s(r) SHALL be 0,1,2,3 for NB = 4 or 6, and 0,1,3,4 for NB = 8.
REQ-016 Forward mode SHALL compute out[r][c] = in[r][(c + s(r)) mod NB].
REQ-017 Inverse mode SHALL compute out[r][(c + s(r)) mod NB] = in[r][c].
REQ-018 Bypass mode SHALL pass in_data unchanged; mode 11 SHALL behave as bypass and set the stored error flag for that word.
REQ-019 Transform SHALL be applied combinationally at acceptance; result and error flag SHALL be written into a 2-entry in-order FIFO.
REQ-020 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-021 in_ready SHALL be 1 exactly when FIFO occupancy < 2, derived from registered occupancy only (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 exactly when occupancy > 0; out_data and out_mode_err SHALL show the oldest entry.
REQ-023 Latency: a word accepted at edge N SHALL appear on out_data with out_valid = 1 immediately after edge N when the FIFO was empty.
REQ-024 Throughput: with out_ready held 1, one word per cycle SHALL be sustained with no bubbles.
REQ-025 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1 and preserve order.
REQ-026 At occupancy 2 no push SHALL occur; a pop SHALL raise in_ready on the following cycle.
REQ-027 out_data and out_mode_err SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-028 xfer_cnt SHALL increment by 1 on every edge with out_valid and out_ready both 1, wrapping from 2^CNT_W-1 to 0.
REQ-029 An illegal NB SHALL be reported at elaboration (simulation fatal); no runtime behaviour is defined for it.

Reset
REQ-030 While rst_n = 0: occupancy 0, out_valid 0, in_ready 0, out_mode_err 0, out_data all-zero, xfer_cnt 0, asynchronously.
REQ-031 in_ready SHALL rise on the first rising edge after rst_n deasserts; reset mid-transfer SHALL discard all buffered words with no output.

Verification
REQ-032 NB=4, mode 00, in_data 0x000102030405060708090a0b0c0d0e0f -> out_data 0x00050a0f04090e03080d02070c01060b one cycle later, out_mode_err 0.
REQ-033 NB=4, mode 01, same input -> out_data 0x000d0a0704010e0b0805020f0c090603; feeding the REQ-032 output back in mode 01 -> original input.
REQ-034 NB=8, random state, forward then inverse -> round-trip equals input; row 2 checked against shift 3, row 3 against shift 4.
REQ-035 out_ready held 0, three words offered -> two accepted, in_ready 0 after second; out_ready 1 -> outputs in order, third accepted next cycle, xfer_cnt = 3.
REQ-036 mode 11 word with 0xA5 pattern -> out_data equals input, out_mode_err 1; rst_n pulsed low with two words buffered -> out_valid 0 immediately, xfer_cnt 0, no stale output after release.
